// File: rtl/alu_core_pkg.sv
// Shared definitions for the accumulator ALU: flag indices, IR field positions,
// opcode encodings and the FSM state type.
package alu_core_pkg;

    // Bit positions within Flags
    localparam int ZERO  = 0;
    localparam int CARRY = 1;
    localparam int NEG   = 2;
    localparam int OV    = 3;

    // IR field positions
    localparam int CLS_HI = 7;
    localparam int CLS_LO = 6;
    localparam int SRC_HI = 5;
    localparam int SRC_LO = 2;
    localparam int FN_HI  = 1;
    localparam int FN_LO  = 0;

    localparam logic [1:0] CLS_ARITH = 2'b01;
    localparam logic [1:0] CLS_LOGIC = 2'b10;
    localparam logic [1:0] CLS_SHIFT = 2'b11;

    localparam logic [3:0] SRC_MEM = 4'b0000;
    localparam logic [3:0] SRC_IMM = 4'b0001;

    // Whole-opcode encodings; all live in class 2'b00
    localparam logic [7:0] LOAD_X  = 8'h01;
    localparam logic [7:0] LOAD_I  = 8'h02;
    localparam logic [7:0] STORE_X = 8'h03;
    localparam logic [7:0] STORE_I = 8'h04;
    localparam logic [7:0] JMP     = 8'h05;
    localparam logic [7:0] JZ      = 8'h06;
    localparam logic [7:0] JC      = 8'h07;
    localparam logic [7:0] JN      = 8'h08;
    localparam logic [7:0] JV      = 8'h09;

    typedef enum logic {IDLE, UPDATE} state_t;

endpackage

// File: rtl/alu_adder.sv
// Combinational adder/subtractor shared by ADD, SUB, ADDC and SUBC.
// sub inverts b; the caller supplies the carry-in (1 for plain SUB).
module alu_adder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    input  logic                  sub,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  ov
);

    logic [DATA_WIDTH-1:0] b_eff;

    assign b_eff       = sub ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, cin};
    // Overflow when both addends share a sign that the result does not
    assign ov          = (a[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                         (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);

endmodule

// File: rtl/alu_core.sv
// Accumulator execution unit: decodes IR on an Exec pulse, updates AR/Flags, pulses Done.
// Optional shift class enabled by defining ALU_SHIFT_EN.
module alu_core
    import alu_core_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int INST_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  Exec,
    input  logic [INST_WIDTH-1:0] IR,
    input  logic [DATA_WIDTH-1:0] IBR,
    input  logic [DATA_WIDTH-1:0] MBR,
    output logic [DATA_WIDTH-1:0] AR,
    output logic [3:0]            Flags,
    output logic                  Done
);

    state_t                state, state_n;
    logic                  load, hit, src_ok;
    logic [1:0]            cls, fn;
    logic [3:0]            src;
    logic [DATA_WIDTH-1:0] op, res, sum;
    logic                  c_n, v_n, cout, ov, add_cin;
    logic [3:0]            flg_n;

    assign cls     = IR[CLS_HI:CLS_LO];
    assign src     = IR[SRC_HI:SRC_LO];
    assign fn      = IR[FN_HI:FN_LO];
    assign op      = (src == SRC_IMM) ? IBR : MBR;
    assign src_ok  = (src == SRC_MEM) || (src == SRC_IMM);
    // ADD=0, SUB=1, ADDC/SUBC take the stored carry
    assign add_cin = fn[1] ? Flags[CARRY] : fn[0];

    alu_adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
        .a    (AR),
        .b    (op),
        .cin  (add_cin),
        .sub  (fn[0]),
        .sum  (sum),
        .cout (cout),
        .ov   (ov)
    );

    always_comb begin
        res = AR;
        c_n = Flags[CARRY];
        v_n = Flags[OV];
        hit = 1'b0;
        case (IR)
            LOAD_X: begin res = MBR; hit = 1'b1; end
            LOAD_I: begin res = IBR; hit = 1'b1; end
            STORE_X, STORE_I, JMP, JZ, JC, JN, JV: hit = 1'b0;
            default: begin
                if (cls == CLS_ARITH && src_ok) begin
                    res = sum;
                    c_n = cout;
                    v_n = ov;
                    hit = 1'b1;
                end else if (cls == CLS_LOGIC && src_ok) begin
                    case (fn)
                        2'b00:   res = ~(AR | op);
                        2'b01:   res = ~(AR & op);
                        2'b10:   res = AR ^ op;
                        default: res = ~(AR ^ op);
                    endcase
                    v_n = 1'b0;
                    hit = 1'b1;
                end
`ifdef ALU_SHIFT_EN
                else if (cls == CLS_SHIFT && src == SRC_MEM) begin
                    case (fn)
                        2'b00:   begin res = AR << 1; c_n = AR[DATA_WIDTH-1]; end
                        2'b01:   begin res = AR >> 1; c_n = AR[0]; end
                        2'b10:   begin res = {AR[DATA_WIDTH-2:0], Flags[CARRY]}; c_n = AR[DATA_WIDTH-1]; end
                        default: begin res = {Flags[CARRY], AR[DATA_WIDTH-1:1]}; c_n = AR[0]; end
                    endcase
                    v_n = 1'b0;
                    hit = 1'b1;
                end
`endif
            end
        endcase
        flg_n        = Flags;
        flg_n[ZERO]  = (res == '0);
        flg_n[NEG]   = res[DATA_WIDTH-1];
        flg_n[CARRY] = c_n;
        flg_n[OV]    = v_n;
    end

    // Exec seen while in UPDATE is dropped
    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (Exec && hit) begin
                    state_n = UPDATE;
                    load    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            AR    <= '0;
            Flags <= '0;
        end else if (load) begin
            AR    <= res;
            Flags <= flg_n;
        end
    end

    assign Done = (state == UPDATE);

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Execution unit directly downstream of the instruction-cycle controller.
- On each one-cycle Exec pulse it decodes IR and computes a result from the accumulator and one operand: MBR (memory operand) or IBR (immediate).
- It updates the registered accumulator AR and the status Flags.
- The controller reads AR back for stores and Flags for conditional jumps.

Parameters:
- DATA_WIDTH, 8, width of AR, IBR, MBR and the ALU datapath.
- INST_WIDTH, 8, width of IR; opcode field decoding assumes 8.

Ports:
- clk  input  1  clock.
- arst  input  1  reset, synchronous, active-high.
- Exec  input  1  execute strobe from controller; one-cycle pulse per instruction.
- IR  input  INST_WIDTH  instruction register; stable while Exec=1.
- IBR  input  DATA_WIDTH  immediate operand; stable while Exec=1.
- MBR  input  DATA_WIDTH  memory operand; valid while Exec=1.
- AR  output  DATA_WIDTH  accumulator, registered.
- Flags  output  4  registered status, indexed by the shared ZERO/CARRY/NEG/OV macros.
- Done  output  1  one-cycle pulse, the cycle after an Exec that updated AR or Flags.

Behaviour:
- Reset (arst=1 at posedge clk): AR=0, Flags=0, Done=0, internal state IDLE. Reset wins over a coincident Exec.
- FSM has two states:
  - IDLE -> UPDATE on Exec=1 with a recognised AR-affecting opcode.
  - UPDATE -> IDLE unconditionally. Done=1 only in UPDATE.
  - Exec=1 while in UPDATE is illegal (controller spacing is at least 4 cycles). It is ignored.
- Latency: operands are sampled at the posedge where Exec=1. AR and Flags are valid at that edge, i.e. visible the cycle after Exec, coincident with Done.
- Operand select: IR[5:2]=4'b0000 -> op=MBR; IR[5:2]=4'b0001 -> op=IBR.
- Class select: IR[7:6]=2'b01 arithmetic, 2'b10 logic.
- Arithmetic, by IR[1:0]:
  - 00 ADD: {C,R}=AR+op.
  - 01 SUB: {C,R}=AR+~op+1; C=1 means no borrow.
  - 10 ADDC: AR+op+Cin.
  - 11 SUBC: AR+~op+Cin.
  - Cin = Flags[CARRY] before the operation.
  - OV = signed overflow: operand sign bits equal (after inversion for SUB) and result sign differs.
- Logic, by IR[1:0]: 00 NOR, 01 NAND, 10 XOR, 11 XNOR. C unchanged; OV cleared.
- LOAD_X: AR=MBR. LOAD_I: AR=IBR. Z and N updated; C and OV unchanged.
- All AR-affecting ops: Z=(R==0), N=R[DATA_WIDTH-1].
- STORE_X, STORE_I, JMP, JZ, JC, JN, JV and any undecoded opcode: AR, Flags unchanged; no Done.
- Wrap: 8'hFF+1 -> AR=0, C=1, Z=1. No saturation anywhere.
- Reset mid-operation (arst in UPDATE): state -> IDLE, Done=0, AR and Flags cleared.

Optional Feature:
- Macro ALU_SHIFT_EN.
- When defined, IR[7:6]=2'b11 with IR[5:2]=4'b0000 decodes as shift class, by IR[1:0]:
  - 00 SHL: C=AR[7], R=AR<<1.
  - 01 SHR: C=AR[0], R=AR>>1.
  - 10 ROLC: R={AR[6:0],Cin}, C=AR[7].
  - 11 RORC: R={Cin,AR[7:1]}, C=AR[0].
  - Z and N updated; OV cleared; Done pulses.
- When undefined, IR[7:6]=2'b11 opcodes are undecoded: no state change.

Decomposition:
- Opcode macros (LOAD_X, LOAD_I, STORE_*, J*) and flag index macros (ZERO, CARRY, NEG, OV) live in the shared defines file; IR field positions are added there.
- One sub-module: alu_adder. It is a combinational DATA_WIDTH adder taking a, b, cin, sub and producing sum, cout, ov. It is shared by ADD/SUB/ADDC/SUBC.
- The FSM, operand mux, logic ops and registers stay in alu_core.

Test Plan:
- Reset: arst=1 for 2 cycles with Exec=1 and IR=LOAD_I, IBR=8'h55 -> AR=0, Flags=0, Done=0.
- LOAD_I 8'h7F, then ADD immediate (IR=8'b01000100) IBR=8'h01 -> AR=8'h80, N=1, OV=1, C=0, Z=0; Done pulse the cycle after each Exec.
- AR=8'hFF, ADD immediate 8'h01 -> AR=0, Z=1, C=1. Then ADDC immediate 8'h00 -> AR=8'h01, C=0, Z=0.
- AR=8'h05, SUB with MBR=8'h07 (IR=8'b01000001) -> AR=8'hFE, C=0 (borrow), N=1. Then SUBC immediate 8'h00 -> AR=8'hFD.
- AR=8'hF0, XOR immediate 8'hF0 (IR=8'b10000110) -> AR=0, Z=1, C unchanged, OV=0. Then JZ and STORE_X Exec -> AR, Flags unchanged, no Done.
- ALU_SHIFT_EN defined: AR=8'h81, C=0, ROLC (IR=8'b11000010) -> AR=8'h02, C=1. Undefined build: same IR -> no change, no Done.
